// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_responder_pkg
// Brief   : Shared request-mode constants, FSM state type and mode helper
//           for the MAR/MDR memory responder.
// Revision: 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

    typedef enum logic [1:0] {
        MR_IDLE = 2'b00,
        MR_WAIT = 2'b01,
        MR_RESP = 2'b10
    } mr_state_t;

    localparam logic [1:0] c_mem_req_idle  = 2'b00;
    localparam logic [1:0] c_mem_req_read  = 2'b01;
    localparam logic [1:0] c_mem_req_write = 2'b10;
    localparam logic [1:0] c_mem_req_bad   = 2'b11;

    // Only the two one-hot encodings name a real access.
    function automatic logic mode_is_legal(input logic [1:0] mode);
        return (mode == c_mem_req_read) || (mode == c_mem_req_write);
    endfunction

endpackage : mem_responder_pkg
`default_nettype wire

// File: rtl/mem_responder_mem_array.sv
`default_nettype none
// ============================================================================
// Module  : mem_array
// Brief   : Synchronous single-port word store with registered read data.
//           Contents are never cleared.
// Revision: 1.0 - initial release
// ============================================================================
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int WORD_W     = 16,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    localparam int c_depth = 1 << DEPTH_LOG2;

    logic [WORD_W-1:0] r_mem [0:c_depth-1];
    logic [WORD_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        r_rdata <= r_mem[addr];
    end

    assign rdata = r_rdata;

endmodule : mem_array
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : mem_responder
// Brief   : Memory-side responder for the MAR/MDR port: one request per
//           handshake, WAIT_STATES of latency, then a one-cycle response.
// Revision: 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WORD_W      = 16,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_mode,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int c_cnt_w_raw = $clog2(WAIT_STATES + 1);
    localparam int c_cnt_w     = (c_cnt_w_raw < 1) ? 1 : c_cnt_w_raw;
    localparam logic [c_cnt_w-1:0] c_wait_last =
        c_cnt_w'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
    localparam logic c_zero_wait = (WAIT_STATES == 0);

    mr_state_t           r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [1:0]          r_mode;
    logic [WORD_W-1:0]   r_addr;
    logic [WORD_W-1:0]   r_wdata;
    logic                r_req_ready;
    logic                r_busy;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic [WORD_W-1:0]   r_rsp_rdata;

    logic                w_accept;
    logic                w_enter_resp;
    logic [1:0]          w_src_mode;
    logic [WORD_W-1:0]   w_src_addr;
    logic [WORD_W-1:0]   w_src_wdata;
    logic                w_src_err;
    logic                w_mem_we;
    logic [WORD_W-1:0]   w_mem_rdata;
    logic                w_rsp_err;
    logic                w_rsp_is_read;

    // Whole address is range-checked so high bits never alias into storage.
    function automatic logic addr_oob(input logic [WORD_W-1:0] a);
        return (a >> DEPTH_LOG2) != '0;
    endfunction

    assign w_accept = (r_state == MR_IDLE) && req_valid && r_req_ready;

    // With zero wait states RESP is entered on the accepting edge itself,
    // so storage must see the live request rather than the capture registers.
    assign w_src_mode  = (r_state == MR_IDLE) ? req_mode  : r_mode;
    assign w_src_addr  = (r_state == MR_IDLE) ? req_addr  : r_addr;
    assign w_src_wdata = (r_state == MR_IDLE) ? req_wdata : r_wdata;

    assign w_enter_resp = reset &&
        (c_zero_wait ? w_accept
                     : ((r_state == MR_WAIT) && (r_cnt == c_wait_last)));

    assign w_src_err = !mode_is_legal(w_src_mode) || addr_oob(w_src_addr);
    assign w_mem_we  = w_enter_resp && (w_src_mode == c_mem_req_write) && !w_src_err;

    assign w_rsp_err     = !mode_is_legal(r_mode) || addr_oob(r_addr);
    assign w_rsp_is_read = (r_mode == c_mem_req_read) && !w_rsp_err;

    mem_array #(
        .WORD_W     (WORD_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem_array (
        .clk   (clk),
        .we    (w_mem_we),
        .addr  (w_src_addr[DEPTH_LOG2-1:0]),
        .wdata (w_src_wdata),
        .rdata (w_mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= MR_IDLE;
            r_cnt       <= '0;
            r_mode      <= c_mem_req_idle;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                MR_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_mode      <= req_mode;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (c_zero_wait) begin
                            r_state <= MR_RESP;
                        end else begin
                            r_state <= MR_WAIT;
                            r_cnt   <= '0;
                        end
                    end
                end
                MR_WAIT: begin
                    if (r_cnt == c_wait_last) begin
                        r_state <= MR_RESP;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                MR_RESP: begin
                    r_state     <= MR_IDLE;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= w_rsp_err;
                    r_rsp_rdata <= w_rsp_is_read ? w_mem_rdata : '0;
                end
                default: begin
                    r_state     <= MR_IDLE;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign busy      = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule : mem_responder
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_responder
// Brief   : Self-checking bench: WAIT_STATES=2 instance for the main scenarios
//           and a WAIT_STATES=0 instance for back-to-back throughput.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam logic [1:0] RD  = 2'b01;
    localparam logic [1:0] WR  = 2'b10;
    localparam int         LAT = 4;   // WAIT_STATES + 2 sample points after acceptance

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        req_valid = 1'b0, req_ready, rsp_valid, rsp_err, busy;
    logic [1:0]  req_mode = 2'b00;
    logic [15:0] req_addr = '0, req_wdata = '0, rsp_rdata;

    logic        z_req_valid = 1'b0, z_req_ready, z_rsp_valid, z_rsp_err, z_busy;
    logic [1:0]  z_req_mode = 2'b00;
    logic [15:0] z_req_addr = '0, z_req_wdata = '0, z_rsp_rdata;

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [15:0] mdl [int];

    typedef struct {
        logic        seen;
        int          lat;
        logic        err;
        logic [15:0] rdata;
        logic        valid_next;
        logic        err_next;
        logic [15:0] rdata_next;
        logic        busy1;
        logic        ready1;
    } rsp_t;

    always #5 clk = ~clk;

    mem_responder #(.WORD_W(16), .DEPTH_LOG2(10), .WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    mem_responder #(.WORD_W(16), .DEPTH_LOG2(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_mode(z_req_mode), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err), .busy(z_busy)
    );

    // Drives one request on the WAIT_STATES=2 instance and collects what comes back.
    // rst_at>0 pulls reset low at that sample point after acceptance.
    task automatic issue(input logic [1:0] mode, input logic [15:0] addr,
                         input logic [15:0] wdata, input int rst_at, output rsp_t r);
        r.seen = 1'b0; r.lat = -1; r.err = 1'bx; r.rdata = 'x;
        r.valid_next = 1'bx; r.err_next = 1'bx; r.rdata_next = 'x;
        for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
        if (!req_ready) return;
        req_valid = 1'b1; req_mode = mode; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        req_mode = 2'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
        r.busy1 = busy; r.ready1 = req_ready;
        for (int k = 1; k <= 12; k++) begin
            if (rsp_valid) begin
                r.seen = 1'b1; r.lat = k; r.err = rsp_err; r.rdata = rsp_rdata;
                break;
            end
            reset = (k == rst_at) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        reset = 1'b1;
        if (r.seen) begin
            @(negedge clk);
            r.valid_next = rsp_valid; r.err_next = rsp_err; r.rdata_next = rsp_rdata;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_cnt++; if (req_ready !== 1'b0) $display("FAIL rst_ready_low: got %b expected 0", req_ready); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL rst_busy_valid: got busy=%b valid=%b expected 0/0", busy, rsp_valid); else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
        check_cnt++; if (req_ready !== 1'b1) $display("FAIL rel_ready: got %b expected 1", req_ready); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0) $display("FAIL rel_outputs: got busy=%b valid=%b err=%b expected 0/0/0", busy, rsp_valid, rsp_err); else pass_cnt++;
        check_cnt++; if (rsp_rdata !== 16'h0000) $display("FAIL rel_rdata: got %h expected 0000", rsp_rdata); else pass_cnt++;
        check_cnt++; if (z_req_ready !== 1'b1) $display("FAIL rel_ready_ws0: got %b expected 1", z_req_ready); else pass_cnt++;
    endtask

    task automatic test_write_read();
        rsp_t r;
        issue(WR, 16'h0000, 16'h0000, 0, r); mdl[0] = 16'h0000;
        check_cnt++; if (r.lat !== LAT || r.err !== 1'b0) $display("FAIL init0: got lat=%0d err=%b expected %0d/0", r.lat, r.err, LAT); else pass_cnt++;
        issue(WR, 16'h0005, 16'hBEEF, 0, r); mdl[5] = 16'hBEEF;
        check_cnt++; if (r.lat !== LAT) $display("FAIL wr5_lat: got %0d expected %0d", r.lat, LAT); else pass_cnt++;
        check_cnt++; if (r.err !== 1'b0 || r.rdata !== 16'h0000) $display("FAIL wr5_rsp: got err=%b rdata=%h expected 0/0000", r.err, r.rdata); else pass_cnt++;
        check_cnt++; if (r.busy1 !== 1'b1 || r.ready1 !== 1'b0) $display("FAIL wr5_busy: got busy=%b ready=%b expected 1/0", r.busy1, r.ready1); else pass_cnt++;
        check_cnt++; if (r.valid_next !== 1'b0) $display("FAIL wr5_one_cycle: got %b expected 0", r.valid_next); else pass_cnt++;
        issue(RD, 16'h0005, 16'h0000, 0, r);
        check_cnt++; if (r.lat !== LAT || r.err !== 1'b0) $display("FAIL rd5_lat_err: got lat=%0d err=%b expected %0d/0", r.lat, r.err, LAT); else pass_cnt++;
        check_cnt++; if (r.rdata !== 16'hBEEF) $display("FAIL rd5_data: got %h expected beef", r.rdata); else pass_cnt++;
        check_cnt++; if (r.rdata_next !== 16'hBEEF || r.err_next !== 1'b0) $display("FAIL rd5_hold: got rdata=%h err=%b expected beef/0", r.rdata_next, r.err_next); else pass_cnt++;
    endtask

    task automatic test_oob();
        rsp_t r;
        issue(WR, 16'h0400, 16'h1234, 0, r);
        check_cnt++; if (r.lat !== LAT || r.err !== 1'b1 || r.rdata !== 16'h0000) $display("FAIL oob_wr: got lat=%0d err=%b rdata=%h expected %0d/1/0000", r.lat, r.err, r.rdata, LAT); else pass_cnt++;
        issue(RD, 16'h0000, 16'h0000, 0, r);
        check_cnt++; if (r.err !== 1'b0 || r.rdata !== 16'h0000) $display("FAIL oob_alias: got err=%b rdata=%h expected 0/0000", r.err, r.rdata); else pass_cnt++;
        issue(RD, 16'hFFFF, 16'h0000, 0, r);
        check_cnt++; if (r.lat !== LAT || r.err !== 1'b1 || r.rdata !== 16'h0000) $display("FAIL oob_rd: got lat=%0d err=%b rdata=%h expected %0d/1/0000", r.lat, r.err, r.rdata, LAT); else pass_cnt++;
        issue(WR, 16'h03FF, 16'h5A5A, 0, r); mdl[16'h03FF] = 16'h5A5A;
        check_cnt++; if (r.err !== 1'b0) $display("FAIL top_wr: got err=%b expected 0", r.err); else pass_cnt++;
        issue(RD, 16'h03FF, 16'h0000, 0, r);
        check_cnt++; if (r.err !== 1'b0 || r.rdata !== 16'h5A5A) $display("FAIL top_rd: got err=%b rdata=%h expected 0/5a5a", r.err, r.rdata); else pass_cnt++;
    endtask

    task automatic test_bad_mode();
        rsp_t r;
        issue(WR, 16'h0001, 16'h1111, 0, r); mdl[1] = 16'h1111;
        issue(2'b11, 16'h0001, 16'h2222, 0, r);
        check_cnt++; if (r.lat !== LAT || r.err !== 1'b1 || r.rdata !== 16'h0000) $display("FAIL mode11: got lat=%0d err=%b rdata=%h expected %0d/1/0000", r.lat, r.err, r.rdata, LAT); else pass_cnt++;
        issue(2'b00, 16'h0001, 16'h3333, 0, r);
        check_cnt++; if (r.lat !== LAT || r.err !== 1'b1 || r.rdata !== 16'h0000) $display("FAIL mode00: got lat=%0d err=%b rdata=%h expected %0d/1/0000", r.lat, r.err, r.rdata, LAT); else pass_cnt++;
        issue(RD, 16'h0001, 16'h0000, 0, r);
        check_cnt++; if (r.rdata !== 16'h1111) $display("FAIL mode_mem: got %h expected 1111", r.rdata); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        rsp_t r;
        issue(WR, 16'h0007, 16'h5555, 0, r); mdl[7] = 16'h5555;
        issue(WR, 16'h0007, 16'hAAAA, 1, r);
        check_cnt++; if (r.seen !== 1'b0) $display("FAIL rst_wait_rsp: got rsp_valid seen=%b expected 0", r.seen); else pass_cnt++;
        check_cnt++; if (req_ready !== 1'b1 || busy !== 1'b0) $display("FAIL rst_wait_idle: got ready=%b busy=%b expected 1/0", req_ready, busy); else pass_cnt++;
        issue(RD, 16'h0007, 16'h0000, 0, r);
        check_cnt++; if (r.rdata !== 16'h5555) $display("FAIL rst_wait_mem: got %h expected 5555", r.rdata); else pass_cnt++;
        issue(WR, 16'h0008, 16'hC3C3, 3, r); mdl[8] = 16'hC3C3;
        check_cnt++; if (r.seen !== 1'b0) $display("FAIL rst_resp_rsp: got rsp_valid seen=%b expected 0", r.seen); else pass_cnt++;
        issue(RD, 16'h0008, 16'h0000, 0, r);
        check_cnt++; if (r.rdata !== 16'hC3C3) $display("FAIL rst_resp_mem: got %h expected c3c3", r.rdata); else pass_cnt++;
    endtask

    task automatic test_random();
        rsp_t        r;
        int          pool[$];
        logic [1:0]  m;
        logic [15:0] a, d, e_rd;
        logic        e_err;
        int          sel;
        for (int i = 0; i < 32; i++) pool.push_back(i);
        pool.push_back(1023);
        foreach (pool[i]) begin
            d = 16'($urandom);
            issue(WR, 16'(pool[i]), d, 0, r);
            mdl[pool[i]] = d;
            check_cnt++; if (r.err !== 1'b0 || r.lat !== LAT) $display("FAIL pool_init a=%0d: got err=%b lat=%0d expected 0/%0d", pool[i], r.err, r.lat, LAT); else pass_cnt++;
        end
        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 9);
            m = (sel < 4) ? RD : (sel < 8) ? WR : (sel == 8) ? 2'b00 : 2'b11;
            a = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(1024, 65535))
                                            : 16'(pool[$urandom_range(0, pool.size() - 1)]);
            d = 16'($urandom);
            e_err = !(m == RD || m == WR) || (int'(a) >= 1024);
            e_rd  = (!e_err && m == RD) ? mdl[int'(a)] : 16'h0000;
            if (!e_err && m == WR) mdl[int'(a)] = d;
            issue(m, a, d, 0, r);
            check_cnt++; if (r.lat !== LAT) $display("FAIL rnd%0d_lat: got %0d expected %0d", t, r.lat, LAT); else pass_cnt++;
            check_cnt++; if (r.err !== e_err) $display("FAIL rnd%0d_err m=%b a=%h: got %b expected %b", t, m, a, r.err, e_err); else pass_cnt++;
            check_cnt++; if (r.rdata !== e_rd) $display("FAIL rnd%0d_rdata m=%b a=%h: got %h expected %h", t, m, a, r.rdata, e_rd); else pass_cnt++;
        end
    endtask

    // WAIT_STATES=0 instance: req_valid held high, one response every 2 cycles.
    task automatic test_back_to_back();
        localparam int NREQ = 16;
        logic        e_err_q[$];
        logic [15:0] e_rd_q[$];
        int          e_cyc_q[$];
        logic [15:0] zm [int];
        logic [15:0] pa, a, d;
        logic [1:0]  m;
        logic        e_err;
        int          sent = 0, got = 0, ec;
        pa = '0;
        z_req_valid = 1'b1;
        for (int cyc = 0; cyc < 120 && got < NREQ; cyc++) begin
            if (z_rsp_valid) begin
                got++;
                check_cnt++;
                if (e_cyc_q.size() == 0) $display("FAIL b2b_extra: got unexpected response at cycle %0d expected none", cyc);
                else begin
                    pass_cnt++;
                    ec = e_cyc_q.pop_front();
                    check_cnt++; if (cyc !== ec) $display("FAIL b2b_timing: got cycle %0d expected %0d", cyc, ec); else pass_cnt++;
                    check_cnt++; if (z_rsp_err !== e_err_q[0]) $display("FAIL b2b_err: got %b expected %b", z_rsp_err, e_err_q[0]); else pass_cnt++;
                    check_cnt++; if (z_rsp_rdata !== e_rd_q[0]) $display("FAIL b2b_rdata: got %h expected %h", z_rsp_rdata, e_rd_q[0]); else pass_cnt++;
                    void'(e_err_q.pop_front()); void'(e_rd_q.pop_front());
                end
            end else begin
                check_cnt++; if (z_rsp_err !== 1'b0) $display("FAIL b2b_err_idle: got %b expected 0", z_rsp_err); else pass_cnt++;
            end
            if (z_req_ready && sent < NREQ) begin
                if (sent % 2 == 0) begin
                    pa = (sent == 6) ? 16'(16'h0400 + $urandom_range(0, 255)) : 16'($urandom_range(0, 1023));
                    m = WR;
                end else begin
                    m = RD;
                end
                a = pa; d = 16'($urandom);
                e_err = !(m == RD || m == WR) || (int'(a) >= 1024);
                e_err_q.push_back(e_err);
                e_rd_q.push_back((!e_err && m == RD) ? zm[int'(a)] : 16'h0000);
                if (!e_err && m == WR) zm[int'(a)] = d;
                e_cyc_q.push_back(cyc + 2);
                z_req_mode = m; z_req_addr = a; z_req_wdata = d;
                sent++;
            end else begin
                if (sent >= NREQ) z_req_valid = 1'b0;
                z_req_mode = 2'($urandom); z_req_addr = 16'($urandom); z_req_wdata = 16'($urandom);
            end
            @(negedge clk);
        end
        z_req_valid = 1'b0;
        check_cnt++; if (got !== NREQ || e_cyc_q.size() !== 0) $display("FAIL b2b_count: got %0d responses, %0d pending expected %0d/0", got, e_cyc_q.size(), NREQ); else pass_cnt++;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_oob();
        test_bad_mode();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule : tb_mem_responder
`default_nettype wire
